// File: rtl/div_engine_if.sv
// -----------------------------------------------------------------------------
// div_engine_if
// Handshake/data bundle between the divider and its requester (the
// accelerator write-back machine).
//   start_div   : request, sampled only while the divider is idle
//   divident    : dividend, captured on the accepting edge
//   divisor     : divisor, captured on the accepting edge
//   quotient    : registered result, stable until the next accepted start
//   remainder   : registered result, stable until the next accepted start
//   done        : one-cycle completion pulse
//   busy        : high from accept through the done cycle
//   div_by_zero : set with a result whose divisor was 0
// master = requester side, slave = divider side.
// -----------------------------------------------------------------------------
interface div_engine_if #(
   parameter int WIDTH = 16
);
   logic             start_div;
   logic [WIDTH-1:0] divident;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             done;
   logic             busy;
   logic             div_by_zero;

   modport master (
      output start_div, divident, divisor,
      input  quotient, remainder, done, busy, div_by_zero
   );

   modport slave (
      input  start_div, divident, divisor,
      output quotient, remainder, done, busy, div_by_zero
   );
endinterface

// File: rtl/div_engine.sv
// -----------------------------------------------------------------------------
// div_engine
// Sequential unsigned restoring divider. One request is accepted while idle,
// STEPS_PER_CYCLE quotient bits are resolved per clock, and the result is
// presented with a one-cycle done pulse. Results hold until the next accept.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   dif   : div_engine_if.slave (start/operands in, results/status out)
// Latency accept edge -> done: ITER+1 edges (divisor 0: done in the next cycle)
// -----------------------------------------------------------------------------

// One restoring step: shift the next dividend MSB into the partial remainder,
// trial-subtract the divisor and keep the difference when it is non-negative.
// The quotient bit is shifted into the bottom of the dividend register as the
// dividend bits are consumed from the top, so after WIDTH steps that register
// holds the quotient.
module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] dvd_in,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] dvd_out
);
   // WIDTH+1 bits: the shifted remainder can reach 2*divisor-1
   logic [WIDTH:0] sh;
   logic [WIDTH:0] diff;

   assign sh   = {rem_in, dvd_in[WIDTH-1]};
   assign diff = sh - {1'b0, dvs};

   // diff[WIDTH] is the borrow: set only when sh < dvs, in which case sh
   // itself is below 2^WIDTH and the top bit can be dropped.
   assign rem_out = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
   assign dvd_out = {dvd_in[WIDTH-2:0], ~diff[WIDTH]};
endmodule

module div_engine #(
   parameter int WIDTH           = 16,
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   div_engine_if.slave dif
);
   localparam int ITER = WIDTH / STEPS_PER_CYCLE;
   localparam int CW   = $clog2(ITER + 1);

   if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4) ||
       (WIDTH % STEPS_PER_CYCLE) != 0) begin : g_bad_param
      $error("div_engine: STEPS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t           state;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q;   // partial remainder (always < divisor between edges)
   logic [WIDTH-1:0] dvd_q;   // unconsumed dividend bits on top, quotient bits below
   logic [WIDTH-1:0] dvs_q;

   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             done_q;
   logic             busy_q;
   logic             dbz_q;

   // Combinational chain of STEPS_PER_CYCLE restoring steps per clock
   logic [STEPS_PER_CYCLE:0][WIDTH-1:0] rem_c;
   logic [STEPS_PER_CYCLE:0][WIDTH-1:0] dvd_c;

   assign rem_c[0] = rem_q;
   assign dvd_c[0] = dvd_q;

   for (genvar s = 0; s < STEPS_PER_CYCLE; s++) begin : g_step
      div_step #(.WIDTH(WIDTH)) u_step (
         .rem_in  (rem_c[s]),
         .dvd_in  (dvd_c[s]),
         .dvs     (dvs_q),
         .rem_out (rem_c[s+1]),
         .dvd_out (dvd_c[s+1])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (dif.start_div) begin
                  dvd_q  <= dif.divident;
                  dvs_q  <= dif.divisor;
                  rem_q  <= '0;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
                  if (dif.divisor == '0) begin
                     // Zero divisor skips iteration: result is known now
                     quotient_q  <= '1;
                     remainder_q <= dif.divident;
                     dbz_q       <= 1'b1;
                     done_q      <= 1'b1;
                     state       <= S_FIN;
                  end else begin
                     state <= S_RUN;
                  end
               end
            end

            S_RUN: begin
               rem_q <= rem_c[STEPS_PER_CYCLE];
               dvd_q <= dvd_c[STEPS_PER_CYCLE];
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(ITER - 1)) begin
                  quotient_q  <= dvd_c[STEPS_PER_CYCLE];
                  remainder_q <= rem_c[STEPS_PER_CYCLE];
                  dbz_q       <= 1'b0;
                  done_q      <= 1'b1;
                  state       <= S_FIN;
               end
            end

            S_FIN: begin
               // start_div is deliberately ignored here
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end

            default: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign dif.quotient    = quotient_q;
   assign dif.remainder   = remainder_q;
   assign dif.done        = done_q;
   assign dif.busy        = busy_q;
   assign dif.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_engine.sv
// -----------------------------------------------------------------------------
// tb_div_engine
// Three dividers (STEPS_PER_CYCLE = 1, 2, 4) share clock and reset. A
// cycle-level model predicts busy/done/results from plain integer division
// and the documented latencies; a compare process checks every instance on
// every negative clock edge. Directed tests add literal expectations.
// -----------------------------------------------------------------------------
module tb_div_engine;
   logic clk;
   logic rst_n;

   logic [2:0]       start_v;
   logic [2:0][15:0] a_v;
   logic [2:0][15:0] b_v;
   logic [2:0][15:0] q_v;
   logic [2:0][15:0] r_v;
   logic [2:0]       done_v;
   logic [2:0]       busy_v;
   logic [2:0]       dbz_v;

   int n_vec;
   int n_bad;
   bit chk_on;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar k = 0; k < 3; k++) begin : g_dut
      div_engine_if #(.WIDTH(16)) dif ();

      div_engine #(.WIDTH(16), .STEPS_PER_CYCLE(1 << k)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .dif   (dif)
      );

      assign dif.start_div = start_v[k];
      assign dif.divident  = a_v[k];
      assign dif.divisor   = b_v[k];
      assign q_v[k]        = dif.quotient;
      assign r_v[k]        = dif.remainder;
      assign done_v[k]     = dif.done;
      assign busy_v[k]     = dif.busy;
      assign dbz_v[k]      = dif.div_by_zero;
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // ---------------- model ----------------
   // m_cnt = busy cycles remaining, including the current one; the last busy
   // cycle is the done cycle and the new result is visible from that cycle on.
   int          m_cnt [3];
   logic [15:0] m_q [3], m_r [3], p_q [3], p_r [3];
   logic        m_z [3], p_z [3];

   initial begin
      for (int k = 0; k < 3; k++) begin
         m_cnt[k] = 0; m_q[k] = 0; m_r[k] = 0; m_z[k] = 0;
         p_q[k] = 0; p_r[k] = 0; p_z[k] = 0;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
               m_cnt[k] = 0; m_q[k] = 0; m_r[k] = 0; m_z[k] = 0;
            end else begin
               if (m_cnt[k] > 0) begin
                  m_cnt[k]--;
               end else if (start_v[k]) begin
                  if (b_v[k] == 0) begin
                     m_cnt[k] = 1;
                     p_q[k] = 16'hFFFF; p_r[k] = a_v[k]; p_z[k] = 1'b1;
                  end else begin
                     m_cnt[k] = (16 >> k) + 1;
                     p_q[k] = a_v[k] / b_v[k]; p_r[k] = a_v[k] % b_v[k]; p_z[k] = 1'b0;
                  end
               end
               if (m_cnt[k] == 1) begin
                  m_q[k] = p_q[k]; m_r[k] = p_r[k]; m_z[k] = p_z[k];
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
               chk($sformatf("spc%0d busy/done/dbz/q/r", 1 << k),
                   {29'd0, busy_v[k], done_v[k], dbz_v[k], q_v[k], r_v[k]},
                   {29'd0, (m_cnt[k] > 0), (m_cnt[k] == 1), m_z[k], m_q[k], m_r[k]});
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   // Starts at a negedge; returns at the negedge of the done cycle with lat =
   // edges from accept (accept edge counted as 1) to done, or -1 on timeout.
   task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
      int guard;
      guard = 0;
      while (busy_v[k] && guard < 100) begin @(negedge clk); guard++; end
      a_v[k] = a; b_v[k] = b; start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
      // operands wander after accept; the latched values must be used
      a_v[k] = 16'($urandom); b_v[k] = 16'($urandom);
      lat = 1;
      while (!done_v[k] && lat < 100) begin @(negedge clk); lat++; end
      if (!done_v[k]) lat = -1;
   endtask

   task automatic wait_idle(input int k);
      int guard;
      guard = 0;
      while (busy_v[k] && guard < 100) begin @(negedge clk); guard++; end
      chk("idle wait", {63'd0, busy_v[k]}, 64'd0);
   endtask

   typedef struct { logic [15:0] a, b, q, r; } vec_t;
   vec_t vt [5];

   initial begin
      int lat, ndone, bcnt;
      n_vec = 0; n_bad = 0; chk_on = 0;
      rst_n = 1'b0;
      start_v = '0; a_v = '0; b_v = '0;

      repeat (3) @(negedge clk);
      chk_on = 1;
      chk("reset q",    q_v[0], 0);
      chk("reset r",    r_v[0], 0);
      chk("reset ctl",  {busy_v[0], done_v[0], dbz_v[0]}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // nominal, with busy width measured
      a_v[0] = 20000; b_v[0] = 10; start_v[0] = 1;
      @(negedge clk); start_v[0] = 0;
      bcnt = 0; lat = 1;
      while (!done_v[0] && lat < 100) begin bcnt += busy_v[0]; @(negedge clk); lat++; end
      bcnt += busy_v[0];
      chk("nominal latency", lat, 17);
      chk("nominal busy cycles", bcnt, 17);
      chk("nominal q", q_v[0], 2000);
      chk("nominal r", r_v[0], 0);
      chk("nominal dbz", dbz_v[0], 0);

      // boundaries
      vt[0] = '{16'd65535, 16'd7, 16'd9362, 16'd1};
      vt[1] = '{16'd5,     16'd9, 16'd0,    16'd5};
      vt[2] = '{16'd0,     16'd3, 16'd0,    16'd0};
      vt[3] = '{16'd65535, 16'd1, 16'd65535, 16'd0};
      vt[4] = '{16'd9,     16'd2, 16'd4,    16'd1};
      for (int i = 0; i < 4; i++) begin
         run_op(0, vt[i].a, vt[i].b, lat);
         chk($sformatf("bound%0d lat", i), lat, 17);
         chk($sformatf("bound%0d q", i), q_v[0], vt[i].q);
         chk($sformatf("bound%0d r", i), r_v[0], vt[i].r);
      end

      // divide by zero, then a normal divide clears the flag
      run_op(0, 123, 0, lat);
      chk("dbz latency", lat, 1);
      chk("dbz q", q_v[0], 16'hFFFF);
      chk("dbz r", r_v[0], 123);
      chk("dbz flag", dbz_v[0], 1);
      run_op(0, vt[4].a, vt[4].b, lat);
      chk("after dbz q", q_v[0], 4);
      chk("after dbz r", r_v[0], 1);
      chk("after dbz flag", dbz_v[0], 0);

      // busy collision: restarts at accept+5 and in the done cycle are ignored
      wait_idle(0);
      a_v[0] = 100; b_v[0] = 3; start_v[0] = 1;
      @(negedge clk); start_v[0] = 0;
      ndone = 0;
      for (int c = 1; c <= 45; c++) begin
         ndone += done_v[0];
         if (c == 5 || c == 17) begin
            a_v[0] = 50; b_v[0] = 5; start_v[0] = 1;
         end else begin
            start_v[0] = 0;
         end
         @(negedge clk);
      end
      chk("collision done count", ndone, 1);
      chk("collision q held", q_v[0], 33);
      chk("collision r held", r_v[0], 1);

      // asynchronous reset mid-operation
      a_v[0] = 20000; b_v[0] = 10; start_v[0] = 1;
      @(negedge clk); start_v[0] = 0;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst q", q_v[0], 0);
      chk("async rst r", r_v[0], 0);
      chk("async rst ctl", {busy_v[0], done_v[0], dbz_v[0]}, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(0, 20000, 10, lat);
      chk("post reset latency", lat, 17);
      chk("post reset q", q_v[0], 2000);

      // start held high: re-accepted every ITER+2 cycles
      wait_idle(0);
      a_v[0] = 9; b_v[0] = 2; start_v[0] = 1;
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         ndone += done_v[0];
      end
      start_v[0] = 0;
      chk("back-to-back done count", ndone, 2);
      wait_idle(0);

      // parameter sweep on the 2- and 4-step instances
      for (int k = 1; k < 3; k++) begin
         for (int i = 0; i < 8; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = (i == 0) ? 16'd0 : (i < 3) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
            run_op(k, a, b, lat);
            chk($sformatf("spc%0d lat", 1 << k), lat, (b == 0) ? 1 : (16 >> k) + 1);
         end
         wait_idle(k);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
